tmr_recovery_ctrl: RTL and testbench

- Sits directly downstream of the TMR voter and consumes its per-cycle Voter_state disagreement mask.
- Filters transient mismatches, then runs a recovery sequence: holds all cores, resets the disagreeing core, releases.
- Keeps saturating per-core fault counters.
- Escalates to a system reset request on loss of majority or on a repeat-offending core.

---
 rtl/tmr_recovery_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_tmr_recovery_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/tmr_recovery_ctrl.sv
// TMR recovery controller: filters voter mismatches, recovers a single faulty core, escalates to FATAL.
// Optional TMR_FAULT_LOG_EN adds last_fault_pc / last_fault_mask capture outputs.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | all cores agree, watching the voter mask
// CONFIRM | single-core mismatch seen, counting identical samples
// HOLD    | all cores frozen, fault counted, waiting HOLD_CYCLES
// RESYNC  | faulty core held in reset for RESYNC_CYCLES, others frozen
// FATAL   | no majority or repeat offender, system reset requested
module tmr_recovery_ctrl #(
  parameter int CONFIRM_CYCLES = 2,
  parameter int HOLD_CYCLES    = 4,
  parameter int RESYNC_CYCLES  = 2,
  parameter int MAX_FAULTS     = 4,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst_in,
  input  logic [2:0]       Voter_state,
  input  logic [31:0]      PC_Top,
  output logic             core_hold,
  output logic [2:0]       core_rst_n,
  output logic             sys_rst_req,
  output logic             fatal,
  output logic             recov_busy,
  output logic [CNT_W-1:0] fault_cnt_A,
  output logic [CNT_W-1:0] fault_cnt_B,
  output logic [CNT_W-1:0] fault_cnt_C
`ifdef TMR_FAULT_LOG_EN
  ,
  output logic [31:0]      last_fault_pc,
  output logic [2:0]       last_fault_mask
`endif
);

  localparam int TMR_MAX = (HOLD_CYCLES > RESYNC_CYCLES) ? HOLD_CYCLES : RESYNC_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int CONF_W  = $clog2(CONFIRM_CYCLES + 1);

  localparam logic [TMR_W-1:0]  HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0]  RES_LAST  = TMR_W'(RESYNC_CYCLES - 1);
  localparam logic [CONF_W-1:0] CONF_LAST = CONF_W'(CONFIRM_CYCLES - 1);
  localparam logic [CNT_W-1:0]  MAX_F     = CNT_W'(MAX_FAULTS);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CONFIRM, ST_HOLD, ST_RESYNC, ST_FATAL
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        mask_q, mask_d;
  logic [CONF_W-1:0] conf_q, conf_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [CNT_W-1:0]  cnt_q [3];
  logic [CNT_W-1:0]  cnt_d [3];
  logic              hold_q, hold_d;
  logic [2:0]        rstn_q, rstn_d;
  logic              sys_q, sys_d;
  logic              fatal_q, fatal_d;
  logic              busy_q, busy_d;

  logic single, clean, nomaj;
  logic hold_entry, fatal_entry, over_max;

  assign clean  = (Voter_state == 3'b000);
  assign single = (Voter_state == 3'b001) || (Voter_state == 3'b010) ||
                  (Voter_state == 3'b100);
  assign nomaj  = !clean && !single;

  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    conf_d      = conf_q;
    tmr_d       = tmr_q;
    cnt_d       = cnt_q;
    hold_entry  = 1'b0;
    fatal_entry = 1'b0;
    over_max    = 1'b0;

    for (int i = 0; i < 3; i++) begin
      if (mask_q[i] && (cnt_q[i] >= MAX_F)) over_max = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (single) begin
          mask_d = Voter_state;
          conf_d = CONF_W'(1);
          if (CONFIRM_CYCLES == 1) hold_entry = 1'b1;
          else                     state_d    = ST_CONFIRM;
        end else if (nomaj) begin
          mask_d      = Voter_state;
          fatal_entry = 1'b1;
        end
      end
      ST_CONFIRM: begin
        if (nomaj) begin
          mask_d      = Voter_state;
          fatal_entry = 1'b1;
        end else if (clean) begin
          state_d = ST_IDLE;
        end else if (Voter_state == mask_q) begin
          if (conf_q == CONF_LAST) hold_entry = 1'b1;
          else                     conf_d     = conf_q + CONF_W'(1);
        end else begin
          mask_d = Voter_state;
          conf_d = CONF_W'(1);
        end
      end
      ST_HOLD: begin
        if (tmr_q == '0) begin
          state_d = ST_RESYNC;
          tmr_d   = RES_LAST;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_RESYNC: begin
        if (tmr_q == '0) begin
          if (over_max) fatal_entry = 1'b1;
          else          state_d     = ST_IDLE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      ST_FATAL: state_d = ST_FATAL;
      default:  state_d = ST_IDLE;
    endcase

    if (hold_entry) begin
      state_d = ST_HOLD;
      tmr_d   = HOLD_LAST;
      for (int i = 0; i < 3; i++) begin
        if (mask_d[i] && (cnt_q[i] != '1)) cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
    if (fatal_entry) state_d = ST_FATAL;

    // Outputs are decoded from the next state so they change on the transition edge.
    hold_d  = (state_d == ST_HOLD) || (state_d == ST_RESYNC) || (state_d == ST_FATAL);
    rstn_d  = (state_d == ST_RESYNC) ? ~mask_d : 3'b111;
    sys_d   = (state_d == ST_FATAL);
    fatal_d = (state_d == ST_FATAL);
    busy_d  = (state_d == ST_CONFIRM) || (state_d == ST_HOLD) || (state_d == ST_RESYNC);
  end

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      conf_q  <= '0;
      tmr_q   <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      hold_q  <= 1'b0;
      rstn_q  <= 3'b111;
      sys_q   <= 1'b0;
      fatal_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      conf_q  <= conf_d;
      tmr_q   <= tmr_d;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      hold_q  <= hold_d;
      rstn_q  <= rstn_d;
      sys_q   <= sys_d;
      fatal_q <= fatal_d;
      busy_q  <= busy_d;
    end
  end

  assign core_hold   = hold_q;
  assign core_rst_n  = rstn_q;
  assign sys_rst_req = sys_q;
  assign fatal       = fatal_q;
  assign recov_busy  = busy_q;
  assign fault_cnt_A = cnt_q[0];
  assign fault_cnt_B = cnt_q[1];
  assign fault_cnt_C = cnt_q[2];

`ifdef TMR_FAULT_LOG_EN
  logic [31:0] log_pc_q;
  logic [2:0]  log_mask_q;

  always_ff @(posedge clk or negedge rst_in) begin
    if (!rst_in) begin
      log_pc_q   <= '0;
      log_mask_q <= '0;
    end else if (hold_entry || fatal_entry) begin
      log_pc_q   <= PC_Top;
      log_mask_q <= mask_d;
    end
  end

  assign last_fault_pc   = log_pc_q;
  assign last_fault_mask = log_mask_q;
`else
  logic unused_pc;
  assign unused_pc = ^PC_Top;
`endif

endmodule

// File: tb/tb_tmr_recovery_ctrl.sv
// Scoreboard bench for tmr_recovery_ctrl: directed voter sequences push expected outputs, a monitor checks them.
// Log outputs are also checked when TMR_FAULT_LOG_EN is defined.
module tb_tmr_recovery_ctrl;

  logic        clk;
  logic        rst_in;
  logic [2:0]  Voter_state;
  logic [31:0] PC_Top;
  logic        core_hold;
  logic [2:0]  core_rst_n;
  logic        sys_rst_req;
  logic        fatal;
  logic        recov_busy;
  logic [7:0]  fault_cnt_A, fault_cnt_B, fault_cnt_C;
`ifdef TMR_FAULT_LOG_EN
  logic [31:0] last_fault_pc;
  logic [2:0]  last_fault_mask;
`endif

  tmr_recovery_ctrl dut (
    .clk         (clk),
    .rst_in      (rst_in),
    .Voter_state (Voter_state),
    .PC_Top      (PC_Top),
    .core_hold   (core_hold),
    .core_rst_n  (core_rst_n),
    .sys_rst_req (sys_rst_req),
    .fatal       (fatal),
    .recov_busy  (recov_busy),
    .fault_cnt_A (fault_cnt_A),
    .fault_cnt_B (fault_cnt_B),
    .fault_cnt_C (fault_cnt_C)
`ifdef TMR_FAULT_LOG_EN
    ,
    .last_fault_pc   (last_fault_pc),
    .last_fault_mask (last_fault_mask)
`endif
  );

  typedef struct {
    string       tag;
    int          tgt;
    logic        hold;
    logic [2:0]  rstn;
    logic        sys;
    logic        fat;
    logic        busy;
    logic [7:0]  ca, cb, cc;
    logic [31:0] lpc;
    logic [2:0]  lmask;
  } exp_t;

  exp_t        q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  ecnt [3];
  logic [31:0] elog_pc;
  logic [2:0]  elog_mask;
  logic [31:0] pc_nx;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(string tag, logic hold, logic [2:0] rstn,
                              logic sys, logic fat, logic busy);
    exp_t e;
    e.tag = tag; e.tgt = 0;
    e.hold = hold; e.rstn = rstn; e.sys = sys; e.fat = fat; e.busy = busy;
    e.ca = ecnt[0]; e.cb = ecnt[1]; e.cc = ecnt[2];
    e.lpc = elog_pc; e.lmask = elog_mask;
    return e;
  endfunction

  task automatic step(input logic [2:0] v, input exp_t e);
    @(negedge clk);
    Voter_state = v;
    PC_Top      = pc_nx;
    pc_nx       = pc_nx + 32'd4;
    e.tgt       = cyc + 1;
    q.push_back(e);
  endtask

  task automatic async_reset();
    exp_t e;
    @(negedge clk);
    #2;
    for (int i = 0; i < 3; i++) ecnt[i] = 8'd0;
    elog_pc = 32'd0; elog_mask = 3'b000;
    e = mk("async_rst", 1'b0, 3'b111, 1'b0, 1'b0, 1'b0);
    e.tgt = cyc;
    q.push_back(e);
    rst_in      = 1'b0;
    Voter_state = 3'b000;
    @(negedge clk);
    @(negedge clk);
    rst_in = 1'b1;
  endtask

  // Full recovery of core m; hold/resync cycles carry voter noise that must be ignored.
  task automatic recover(input logic [2:0] m, input bit to_fatal);
    step(m, mk("confirm", 1'b0, 3'b111, 1'b0, 1'b0, 1'b1));
    for (int i = 0; i < 3; i++) if (m[i]) ecnt[i] = ecnt[i] + 8'd1;
    elog_pc = pc_nx; elog_mask = m;
    step(m,      mk("hold_entry", 1'b1, 3'b111, 1'b0, 1'b0, 1'b1));
    step(3'b011, mk("hold",       1'b1, 3'b111, 1'b0, 1'b0, 1'b1));
    step(3'b110, mk("hold",       1'b1, 3'b111, 1'b0, 1'b0, 1'b1));
    step(3'b000, mk("hold",       1'b1, 3'b111, 1'b0, 1'b0, 1'b1));
    step(3'b111, mk("resync",     1'b1, ~m,     1'b0, 1'b0, 1'b1));
    step(3'b001, mk("resync",     1'b1, ~m,     1'b0, 1'b0, 1'b1));
    if (to_fatal) begin
      elog_pc = pc_nx; elog_mask = m;
      step(3'b000, mk("fatal_entry", 1'b1, 3'b111, 1'b1, 1'b1, 1'b0));
    end else begin
      step(3'b000, mk("release", 1'b0, 3'b111, 1'b0, 1'b0, 1'b0));
    end
  endtask

  initial begin : monitor
    exp_t it;
    logic [30:0] got, want;
    forever begin
      @(negedge clk or negedge rst_in);
      #1;
      while (q.size() > 0 && q[0].tgt <= cyc) begin
        it = q.pop_front();
        got  = {core_hold, core_rst_n, sys_rst_req, fatal, recov_busy,
                fault_cnt_A, fault_cnt_B, fault_cnt_C};
        want = {it.hold, it.rstn, it.sys, it.fat, it.busy, it.ca, it.cb, it.cc};
        checks++;
        if (it.tgt != cyc || got !== want) begin
          errors++;
          $display("FAIL %s cyc=%0d/%0d got hold=%b rst_n=%b sys=%b fatal=%b busy=%b cnt=%0d/%0d/%0d expected hold=%b rst_n=%b sys=%b fatal=%b busy=%b cnt=%0d/%0d/%0d",
                   it.tag, cyc, it.tgt, core_hold, core_rst_n, sys_rst_req, fatal, recov_busy,
                   fault_cnt_A, fault_cnt_B, fault_cnt_C, it.hold, it.rstn, it.sys, it.fat,
                   it.busy, it.ca, it.cb, it.cc);
        end
`ifdef TMR_FAULT_LOG_EN
        checks++;
        if ({last_fault_pc, last_fault_mask} !== {it.lpc, it.lmask}) begin
          errors++;
          $display("FAIL %s_log got pc=%h mask=%b expected pc=%h mask=%b",
                   it.tag, last_fault_pc, last_fault_mask, it.lpc, it.lmask);
        end
`endif
      end
    end
  end

  initial begin
    rst_in      = 1'b0;
    Voter_state = 3'b000;
    PC_Top      = 32'd0;
    pc_nx       = 32'h100;
    for (int i = 0; i < 3; i++) ecnt[i] = 8'd0;
    elog_pc = 32'd0; elog_mask = 3'b000;

    repeat (2) @(negedge clk);
    step(3'b000, mk("reset", 1'b0, 3'b111, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    rst_in = 1'b1;
    step(3'b000, mk("idle", 1'b0, 3'b111, 1'b0, 1'b0, 1'b0));

    // single-cycle glitch on core B is filtered
    step(3'b010, mk("glitch_conf", 1'b0, 3'b111, 1'b0, 1'b0, 1'b1));
    step(3'b000, mk("glitch_drop", 1'b0, 3'b111, 1'b0, 1'b0, 1'b0));
    step(3'b000, mk("glitch_idle", 1'b0, 3'b111, 1'b0, 1'b0, 1'b0));

    recover(3'b001, 1'b0);

    // mask change in CONFIRM relatches onto core C
    step(3'b010, mk("pre_relatch", 1'b0, 3'b111, 1'b0, 1'b0, 1'b1));
    recover(3'b100, 1'b0);
    recover(3'b100, 1'b0);
    recover(3'b100, 1'b0);
    recover(3'b100, 1'b1);
    step(3'b000, mk("fatal_stay", 1'b1, 3'b111, 1'b1, 1'b1, 1'b0));
    step(3'b001, mk("fatal_stay", 1'b1, 3'b111, 1'b1, 1'b1, 1'b0));
    async_reset();

    step(3'b000, mk("idle2", 1'b0, 3'b111, 1'b0, 1'b0, 1'b0));
    elog_pc = pc_nx; elog_mask = 3'b011;
    step(3'b011, mk("nomaj_idle", 1'b1, 3'b111, 1'b1, 1'b1, 1'b0));
    step(3'b000, mk("nomaj_stay", 1'b1, 3'b111, 1'b1, 1'b1, 1'b0));
    async_reset();

    // reset pulse in RESYNC aborts recovery of core B
    pc_nx = 32'h0000_003C;
    step(3'b010, mk("b_conf", 1'b0, 3'b111, 1'b0, 1'b0, 1'b1));
    ecnt[1] = 8'd1; elog_pc = 32'h0000_0040; elog_mask = 3'b010;
    step(3'b010, mk("b_hold_entry", 1'b1, 3'b111, 1'b0, 1'b0, 1'b1));
    repeat (3) step(3'b000, mk("b_hold", 1'b1, 3'b111, 1'b0, 1'b0, 1'b1));
    step(3'b000, mk("b_resync", 1'b1, 3'b101, 1'b0, 1'b0, 1'b1));
    async_reset();
    step(3'b000, mk("post_rst", 1'b0, 3'b111, 1'b0, 1'b0, 1'b0));

    step(3'b001, mk("a_conf", 1'b0, 3'b111, 1'b0, 1'b0, 1'b1));
    elog_pc = pc_nx; elog_mask = 3'b101;
    step(3'b101, mk("nomaj_conf", 1'b1, 3'b111, 1'b1, 1'b1, 1'b0));
    async_reset();
    step(3'b000, mk("final_idle", 1'b0, 3'b111, 1'b0, 1'b0, 1'b0));

    for (int i = 0; i < 8 && q.size() > 0; i++) @(negedge clk);
    #5;
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
